buff_use_sequencer: RTL and testbench

- Sequencer for the buffer-use masks of the convolution datapath. It replaces the fixed 5-bit-count / 4-buffer hardwired decoder with a programmable schedule table and an internal step counter.
- Programmable: buffer count, schedule depth, schedule length, plus single-shot or looping mode, stall and abort.
- Sits between the layer controller (start/abort/stall) and the buffer bank enables (buff_use).

---
 rtl/buff_use_sequencer.sv | 133 +++++++++++++
 tb/tb_buff_use_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buff_use_sequencer.sv
// rtl/buff_use_sequencer.sv - programmable buffer-use schedule sequencer
// Steps through a flop-based schedule table, presenting one NUM_BUF-wide enable mask per step.
module buff_use_sequencer #(
  parameter  int NUM_BUF = 4,
  parameter  int DEPTH   = 32,
  localparam int CNT_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [CNT_W-1:0]   cfg_addr,
  input  logic [NUM_BUF-1:0] cfg_data,
  input  logic [CNT_W-1:0]   cfg_last,
  input  logic               mode_loop,
  input  logic               start,
  input  logic               abort,
  input  logic               stall,
  output logic [NUM_BUF-1:0] buff_use,
  output logic [CNT_W-1:0]   cnt,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output logic               cfg_err
);

  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_d;
  logic [NUM_BUF-1:0] table_q [DEPTH];
  logic [CNT_W-1:0]   last_q, last_d, cnt_d, cnt_inc;
  logic               loop_q, loop_d;
  logic [NUM_BUF-1:0] buff_use_d;
  logic               done_d, wrap_d, cfg_err_d;
  logic               addr_ok, last_ok, start_ok, write_ok;

  assign addr_ok  = {1'b0, cfg_addr} < DEPTH_LIM;
  assign last_ok  = {1'b0, cfg_last} < DEPTH_LIM;
  assign start_ok = (state == IDLE) && start && !abort;
  assign write_ok = (state == IDLE) && cfg_we && addr_ok;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign busy     = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    buff_use_d = buff_use;
    last_d     = last_q;
    loop_d     = loop_q;
    done_d     = 1'b0;
    wrap_d     = 1'b0;
    cfg_err_d  = cfg_we && !write_ok;
    case (state)
      IDLE: begin
        buff_use_d = '0;
        cnt_d      = '0;
        if (start_ok) begin
          if (last_ok) begin
            state_d    = RUN;
            last_d     = cfg_last;
            loop_d     = mode_loop;
            // Step 0 is read before any same-cycle table write lands.
            buff_use_d = table_q[0];
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d    = IDLE;
          buff_use_d = '0;
          cnt_d      = '0;
        end else if (!stall) begin
          if (cnt < last_q) begin
            cnt_d      = cnt_inc;
            buff_use_d = table_q[cnt_inc];
          end else if (loop_q) begin
            cnt_d      = '0;
            buff_use_d = table_q[0];
            wrap_d     = 1'b1;
          end else begin
            state_d    = IDLE;
            cnt_d      = '0;
            buff_use_d = '0;
            done_d     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      buff_use <= '0;
      last_q   <= '0;
      loop_q   <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      buff_use <= buff_use_d;
      last_q   <= last_d;
      loop_q   <= loop_d;
      done     <= done_d;
      wrap     <= wrap_d;
      cfg_err  <= cfg_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else if (write_ok) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_buff_use_sequencer.sv
// tb/tb_buff_use_sequencer.sv - directed self-checking bench for buff_use_sequencer
// A step-level schedule model predicts every output each cycle; literal values pin the model.
module tb_buff_use_sequencer;

  localparam int NUM_BUF = 4;
  localparam int DEPTH   = 26;
  localparam int CNT_W   = $clog2(DEPTH);

  logic               clk;
  logic               rst_n;
  logic               cfg_we;
  logic [CNT_W-1:0]   cfg_addr;
  logic [NUM_BUF-1:0] cfg_data;
  logic [CNT_W-1:0]   cfg_last;
  logic               mode_loop;
  logic               start;
  logic               abort;
  logic               stall;
  logic [NUM_BUF-1:0] buff_use;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic               done;
  logic               wrap;
  logic               cfg_err;

  buff_use_sequencer #(.NUM_BUF(NUM_BUF), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .mode_loop(mode_loop),
    .start(start), .abort(abort), .stall(stall), .buff_use(buff_use),
    .cnt(cnt), .busy(busy), .done(done), .wrap(wrap), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] legacy [26] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'hC, 4'h6, 4'h2,
                              4'h9, 4'hD, 4'h8, 4'hE, 4'h4, 4'h6, 4'h0, 4'h3, 4'hB,
                              4'h1, 4'hD, 4'h8, 4'hC, 4'h2, 4'h3, 4'h9, 4'h8};

  // Model: whether a run is active, which step it is on, and the schedule contents.
  int m_tab [DEPTH];
  bit m_run  = 0;
  int m_step = 0;
  int m_last = 0;
  bit m_loop = 0;
  int e_use  = 0;
  bit e_done = 0;
  bit e_wrap = 0;
  bit e_err  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit was_run;
    e_done = 0;
    e_wrap = 0;
    e_err  = 0;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_tab[i] = 0;
      m_run  = 0;
      m_step = 0;
      e_use  = 0;
    end else begin
      was_run = m_run;
      if (cfg_we && (was_run || int'(cfg_addr) >= DEPTH)) e_err = 1;
      if (!was_run) begin
        if (start && !abort) begin
          if (int'(cfg_last) >= DEPTH) begin
            e_err = 1;
          end else begin
            m_run  = 1;
            m_step = 0;
            m_last = int'(cfg_last);
            m_loop = mode_loop;
          end
        end
      end else if (abort) begin
        m_run = 0;
      end else if (!stall) begin
        if (m_step != m_last) begin
          m_step = m_step + 1;
        end else if (m_loop) begin
          m_step = 0;
          e_wrap = 1;
        end else begin
          m_run  = 0;
          e_done = 1;
        end
      end
      if (!m_run) m_step = 0;
      e_use = m_run ? m_tab[m_step] : 0;
      if (!was_run && cfg_we && int'(cfg_addr) < DEPTH) m_tab[cfg_addr] = int'(cfg_data);
    end
  endtask

  task automatic compare_all();
    check("buff_use", 32'(buff_use), 32'(e_use));
    check("cnt",      32'(cnt),      32'(m_step));
    check("busy",     32'(busy),     32'(m_run));
    check("done",     32'(done),     32'(e_done));
    check("wrap",     32'(wrap),     32'(e_wrap));
    check("cfg_err",  32'(cfg_err),  32'(e_err));
  endtask

  task automatic step();
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wr(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = CNT_W'(a);
    cfg_data = NUM_BUF'(d);
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic go(input int last, input bit loop);
    cfg_last  = CNT_W'(last);
    mode_loop = loop;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic kill();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    int wraps, busyc, donec;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_last = '0;
    mode_loop = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_use", 32'(buff_use), 0);
    check("rst_busy", 32'(busy), 0);

    // Legacy 26-step single-shot schedule
    for (int i = 0; i < 26; i++) wr(i, int'(legacy[i]));
    go(25, 0);
    for (int i = 0; i < 26; i++) begin
      check("t1_use", 32'(buff_use), 32'(legacy[i]));
      check("t1_cnt", 32'(cnt), i);
      if (i < 25) step();
    end
    step();
    check("t1_done", 32'(done), 1);
    check("t1_done_use", 32'(buff_use), 0);
    check("t1_done_busy", 32'(busy), 0);
    step();
    check("t1_done_once", 32'(done), 0);

    // Loop mode, last=3
    go(3, 1);
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      check("t2_use", 32'(buff_use), 0);
      if (wrap) wraps++;
      step();
    end
    check("t2_wraps", wraps, 2);
    kill();
    wr(1, 4'hF);
    go(3, 1);
    for (int i = 0; i < 8; i++) begin
      check("t2b_use", 32'(buff_use), (i % 4 == 1) ? 32'hF : 32'h0);
      check("t2b_wrap", 32'(wrap), (i % 4 == 0 && i > 0) ? 1 : 0);
      step();
    end
    kill();
    wr(1, 0);

    // Stall three cycles on step 6
    go(25, 0);
    busyc = 0;
    donec = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy) busyc++;
      if (done) donec++;
      if (i >= 6 && i <= 9) begin
        check("t3_hold_use", 32'(buff_use), 32'hC);
        check("t3_hold_cnt", 32'(cnt), 6);
      end
      stall = (i >= 6 && i <= 8);
      step();
    end
    stall = 1'b0;
    check("t3_busy_cycles", busyc, 29);
    check("t3_done_pulses", donec, 1);

    // Abort while stalled at step 10
    go(25, 0);
    for (int i = 0; i < 10; i++) step();
    check("t4_use_pre", 32'(buff_use), 32'hD);
    check("t4_cnt_pre", 32'(cnt), 10);
    stall = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    stall = 1'b0;
    check("t4_use", 32'(buff_use), 0);
    check("t4_cnt", 32'(cnt), 0);
    check("t4_busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      check("t4_no_done", 32'(done), 0);
      check("t4_no_wrap", 32'(wrap), 0);
      step();
    end

    // Write during run is rejected and leaves the table unchanged
    go(25, 0);
    step();
    step();
    wr(5, 4'hF);
    check("t5_run_wr_err", 32'(cfg_err), 1);
    step();
    check("t5_err_pulse", 32'(cfg_err), 0);
    kill();
    go(5, 0);
    for (int i = 0; i < 5; i++) step();
    check("t5_rerun_use", 32'(buff_use), 32'h8);
    step();
    check("t5_rerun_done", 32'(done), 1);
    step();

    // Out-of-range start, out-of-range write, start with abort
    cfg_last = CNT_W'(31);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t5_last_err", 32'(cfg_err), 1);
    check("t5_last_busy", 32'(busy), 0);
    step();
    check("t5_last_err_once", 32'(cfg_err), 0);
    wr(27, 4'hF);
    check("t5_addr_err", 32'(cfg_err), 1);
    cfg_last = CNT_W'(3);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("t5_sa_busy", 32'(busy), 0);
    check("t5_sa_err", 32'(cfg_err), 0);

    // Reset mid-run clears state and table
    go(25, 0);
    for (int i = 0; i < 15; i++) step();
    check("t6_cnt_pre", 32'(cnt), 15);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6_use", 32'(buff_use), 0);
    check("t6_cnt", 32'(cnt), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_done", 32'(done), 0);
    go(25, 0);
    for (int i = 0; i < 26; i++) begin
      check("t6_cleared_use", 32'(buff_use), 0);
      step();
    end
    check("t6_rerun_done", 32'(done), 1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
